// File: rtl/acc_sequencer_pkg.sv
// Shared constants and state type for the accumulator control-word sequencer.
// The accumulator decodes its control word through the same bit positions.
package acc_sequencer_pkg;

   localparam int RAM_READ_LATENCY = 2;
   localparam int ACC_LATENCY      = RAM_READ_LATENCY + 3;

   // Control word bit map; addr occupies CTRL_ADDR_LSB upward.
   localparam int CTRL_VALID_BIT   = 0;
   localparam int CTRL_ADDR_LSB    = 1;
   localparam int CTRL_LAST_BIT    = 7;
   localparam int CTRL_FIRST_BIT   = 8;

   localparam int DRAIN_WIDTH      = $clog2(ACC_LATENCY + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } acc_seq_state_t;

endpackage

// File: rtl/acc_sequencer.sv
// Walks num_kernels x kernel_len beats, emitting a registered accumulator
// control word per beat, then waits out the accumulator pipeline before done.
module acc_sequencer
   import acc_sequencer_pkg::*;
#(
   parameter int CTRL_WIDTH = 9,
   parameter int ADDR_WIDTH = 6,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  kernel_len,
   input  logic [CNT_WIDTH-1:0]  num_kernels,
   input  logic                  stall,
   output logic [CTRL_WIDTH-1:0] ctrl,
   output logic                  busy,
   output logic                  done
);

   acc_seq_state_t         state_r, state_s;
   logic [CNT_WIDTH-1:0]   kl_r, kl_s;
   logic [CNT_WIDTH-1:0]   nk_r, nk_s;
   logic [CNT_WIDTH-1:0]   b_r, b_s;
   logic [CNT_WIDTH-1:0]   k_r, k_s;
   logic [DRAIN_WIDTH-1:0] drain_r, drain_s;
   logic [CTRL_WIDTH-1:0]  ctrl_r, ctrl_s;
   logic                   busy_r, busy_s;
   logic                   done_r, done_s;
   logic                   issue_s;
   logic                   beat_last_s;

   // Next-state, counter update and next control word.
   always_comb begin
      state_s     = state_r;
      kl_s        = kl_r;
      nk_s        = nk_r;
      b_s         = b_r;
      k_s         = k_r;
      drain_s     = drain_r;
      ctrl_s      = {CTRL_WIDTH{1'b0}};
      issue_s     = 1'b0;
      beat_last_s = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (start) begin
               // The start cycle issues beat 0 itself so it lands on ctrl at S+1.
               kl_s = kernel_len;
               nk_s = num_kernels;
               b_s  = {CNT_WIDTH{1'b0}};
               k_s  = {CNT_WIDTH{1'b0}};
               if ((kernel_len == {CNT_WIDTH{1'b0}}) || (num_kernels == {CNT_WIDTH{1'b0}})) begin
                  state_s = S_DONE;
               end else begin
                  state_s = S_RUN;
                  issue_s = ~stall;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RUN: begin
            issue_s = ~stall;
         end
         S_DRAIN: begin
            if (drain_r == {DRAIN_WIDTH{1'b0}}) begin
               state_s = S_DONE;
            end else begin
               drain_s = drain_r - DRAIN_WIDTH'(1);
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase

      if (issue_s) begin
         beat_last_s                                = (b_s == (kl_s - CNT_WIDTH'(1)));
         ctrl_s[CTRL_VALID_BIT]                     = 1'b1;
         ctrl_s[CTRL_ADDR_LSB +: ADDR_WIDTH]        = b_s[ADDR_WIDTH-1:0];
         ctrl_s[CTRL_FIRST_BIT]                     = (b_s == {CNT_WIDTH{1'b0}});
         ctrl_s[CTRL_LAST_BIT]                      = beat_last_s;
         if (beat_last_s) begin
            if (k_s == (nk_s - CNT_WIDTH'(1))) begin
               state_s = S_DRAIN;
               drain_s = DRAIN_WIDTH'(ACC_LATENCY - 1);
            end else begin
               state_s = S_RUN;
            end
            b_s = {CNT_WIDTH{1'b0}};
            k_s = k_s + CNT_WIDTH'(1);
         end else begin
            b_s = b_s + CNT_WIDTH'(1);
         end
      end else begin
         beat_last_s = 1'b0;
      end

      busy_s = (state_s != S_IDLE);
      done_s = (state_s == S_DONE);
   end

   // State, counters and registered outputs; reset drops any partial job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         kl_r    <= {CNT_WIDTH{1'b0}};
         nk_r    <= {CNT_WIDTH{1'b0}};
         b_r     <= {CNT_WIDTH{1'b0}};
         k_r     <= {CNT_WIDTH{1'b0}};
         drain_r <= {DRAIN_WIDTH{1'b0}};
         ctrl_r  <= {CTRL_WIDTH{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         kl_r    <= kl_s;
         nk_r    <= nk_s;
         b_r     <= b_s;
         k_r     <= k_s;
         drain_r <= drain_s;
         ctrl_r  <= ctrl_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign ctrl = ctrl_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: beat stream, stall gaps, drain timing,
// zero-length jobs, ignored restarts, mid-job reset and address wrap.
module tb_acc_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] kernel_len;
   logic [7:0] num_kernels;
   logic       stall;
   logic [8:0] ctrl;
   logic       busy;
   logic       done;

   int n_cmp;
   int n_err;
   int n_valid;

   acc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .kernel_len  (kernel_len),
      .num_kernels (num_kernels),
      .stall       (stall),
      .ctrl        (ctrl),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [8:0] beat_word(input int a, input bit f, input bit l);
      logic [5:0] a6;
      a6 = 6'(a);
      return {f, l, a6, 1'b1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a job and checks ctrl/busy/done on every cycle up to done_off+1.
   task automatic run_job(input int kl, input int nk, input int stall_after, input int stall_len,
                          input int done_off, input bit poke, input string name);
      int total;
      int beats;
      int left;
      int j;
      bit prev_stall;
      logic [8:0] exp_ctrl;
      total      = kl * nk;
      beats      = 0;
      left       = stall_len;
      prev_stall = 1'b0;
      n_valid    = 0;
      kernel_len  = 8'(kl);
      num_kernels = 8'(nk);
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= done_off; c++) begin
         if (!prev_stall && beats < total) begin
            j        = beats % kl;
            exp_ctrl = beat_word(j % 64, (j == 0), (j == kl - 1));
            beats++;
         end else begin
            exp_ctrl = 9'd0;
         end
         check_val({name, " ctrl"}, {23'd0, ctrl}, {23'd0, exp_ctrl});
         check_val({name, " busy"}, {31'd0, busy}, 32'd1);
         check_val({name, " done"}, {31'd0, done}, (c == done_off) ? 32'd1 : 32'd0);
         n_valid += int'(ctrl[0]);
         start       = 1'b0;
         kernel_len  = 8'(kl);
         num_kernels = 8'(nk);
         if (poke && c == 1) begin
            start       = 1'b1;
            kernel_len  = 8'(kl + 3);
            num_kernels = 8'(nk + 1);
         end
         stall = (stall_after > 0) && (left > 0) && (beats >= stall_after);
         if (stall) left--;
         prev_stall = stall;
         tick();
      end
      stall = 1'b0;
      check_val({name, " ctrl_after"}, {23'd0, ctrl}, 32'd0);
      check_val({name, " busy_after"}, {31'd0, busy}, 32'd0);
      check_val({name, " done_after"}, {31'd0, done}, 32'd0);
      check_val({name, " beat_count"}, 32'(n_valid), 32'(total));
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      n_valid     = 0;
      rst         = 1'b1;
      start       = 1'b0;
      stall       = 1'b0;
      kernel_len  = 8'd0;
      num_kernels = 8'd0;
      tick();
      tick();
      check_val("reset ctrl", {23'd0, ctrl}, 32'd0);
      check_val("reset busy", {31'd0, busy}, 32'd0);
      check_val("reset done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      tick();

      // 3x2: beats S+1..S+6, done S+11
      run_job(3, 2, 0, 0, 11, 1'b0, "k3n2");
      // 1x4: first=last each beat, done 5 after beat 4
      run_job(1, 4, 0, 0, 9, 1'b0, "k1n4");
      // 4x1, stall two cycles after beat 2: beats at 1,2,5,6, done 11
      run_job(4, 1, 2, 2, 11, 1'b0, "k4n1_stall");
      // zero-length jobs
      run_job(0, 5, 0, 0, 1, 1'b0, "kl0");
      run_job(5, 0, 0, 0, 1, 1'b0, "nk0");
      // start while busy must not re-latch lengths
      run_job(2, 1, 0, 0, 7, 1'b1, "restart_ignored");
      // 70 beats: addr wraps at beat 65, done 75
      run_job(70, 1, 0, 0, 75, 1'b0, "k70_wrap");

      // reset after beat 2 of 5
      kernel_len  = 8'd5;
      num_kernels = 8'd1;
      start       = 1'b1;
      tick();
      start = 1'b0;
      check_val("rst_mid beat1", {23'd0, ctrl}, {23'd0, beat_word(0, 1'b1, 1'b0)});
      tick();
      check_val("rst_mid beat2", {23'd0, ctrl}, {23'd0, beat_word(1, 1'b0, 1'b0)});
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("rst_mid ctrl", {23'd0, ctrl}, 32'd0);
      check_val("rst_mid busy", {31'd0, busy}, 32'd0);
      check_val("rst_mid done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_val("rst_quiet done", {31'd0, done}, 32'd0);
         check_val("rst_quiet ctrl", {23'd0, ctrl}, 32'd0);
      end
      run_job(5, 1, 0, 0, 10, 1'b0, "rst_restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
